// File: rtl/npu_pkg.sv
// Shared NPU definitions: default array geometry and the operand-feeder FSM state type.
package npu_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N          = 4;
  localparam int DEF_K_MAX      = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data}; the per-lane building block of the skew.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] din,
  output logic [WIDTH:0] dout
);

  logic [WIDTH:0] stage [DEPTH];

  // Shift one stage per cycle; every stage clears on reset so no stale beat leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this is a short shift chain, not a RAM, so every entry is reset; an aborted tile must not reappear.
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Systolic-array operand feeder: accepts A/B vectors per beat and skews lane i by i+1 cycles.
module skew_feeder
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int K_MAX      = DEF_K_MAX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_WIDTH-1:0]      in_a,
  input  logic [N*DATA_WIDTH-1:0]      in_b,
  input  logic                         in_last,
  output logic [N*DATA_WIDTH-1:0]      a_row,
  output logic [N*DATA_WIDTH-1:0]      b_col,
  output logic [N-1:0]                 lane_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(K_MAX+1)-1:0]   beat_count,
  output logic                         overflow
);

  localparam int BW = $clog2(K_MAX + 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(N - 1);
  localparam logic [BW-1:0] COUNT_MAX  = BW'(K_MAX);

  feeder_state_t state, state_nxt;
  logic [CW-1:0] flush_cnt;
  logic          accept;

  assign in_ready = (state == ST_IDLE) || (state == ST_STREAM);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // Next-state logic: FLUSH lasts N cycles so the deepest lane drains before done.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nxt = in_last ? ST_FLUSH : ST_STREAM;
      ST_STREAM: if (accept && in_last) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (flush_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and flush down-counter (loaded with N-1 on FLUSH entry).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (state != ST_FLUSH && state_nxt == ST_FLUSH) flush_cnt <= FLUSH_LOAD;
      else if (state == ST_FLUSH)                     flush_cnt <= flush_cnt - CW'(1);
    end
  end

  // Beat counter and sticky overflow; both restart on the first beat of a new tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        beat_count <= BW'(1);
        overflow   <= 1'b0;
      end else if (beat_count == COUNT_MAX) begin
        overflow   <= 1'b1;
      end else begin
        beat_count <= beat_count + BW'(1);
      end
    end
  end

  // One delay line per lane per operand; lane i is i+1 registers deep, bubbles enter as zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH:0] a_in, b_in, a_out, b_out;

    assign a_in = accept ? {1'b1, in_a[i*DATA_WIDTH +: DATA_WIDTH]} : '0;
    assign b_in = accept ? {1'b1, in_b[i*DATA_WIDTH +: DATA_WIDTH]} : '0;

    skew_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_dl_a (
      .clk  (clk),
      .rst  (rst),
      .din  (a_in),
      .dout (a_out)
    );

    skew_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_dl_b (
      .clk  (clk),
      .rst  (rst),
      .din  (b_in),
      .dout (b_out)
    );

    assign a_row[i*DATA_WIDTH +: DATA_WIDTH] = a_out[DATA_WIDTH-1:0];
    assign b_col[i*DATA_WIDTH +: DATA_WIDTH] = b_out[DATA_WIDTH-1:0];
    assign lane_valid[i] = a_out[DATA_WIDTH] & b_out[DATA_WIDTH];
  end

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width in bits (signed two's complement).
REQ-002 SHALL have parameter N, default 4, array dimension (number of row lanes = number of column lanes).
REQ-003 SHALL have parameter K_MAX, default 255, maximum beats per tile.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-008 SHALL have port in_a, input, N*DATA_WIDTH, A column vector, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_b, input, N*DATA_WIDTH, B row vector, same packing.
REQ-010 SHALL have port in_last, input, 1, marks final beat of tile; qualified by in_valid.
REQ-011 SHALL have port a_row, output, N*DATA_WIDTH, skewed A operands to array row inputs.
REQ-012 SHALL have port b_col, output, N*DATA_WIDTH, skewed B operands to array column inputs.
REQ-013 SHALL have port lane_valid, output, N, per-lane valid driving PE valid_in.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when the tile has fully drained.
REQ-016 SHALL have port beat_count, output, $clog2(K_MAX+1), beats accepted in current/last tile.
REQ-017 SHALL have port overflow, output, 1, sticky: more than K_MAX beats in a tile.

Function
REQ-018 SHALL accept a beat in any cycle where in_valid and in_ready are both 1.
REQ-019 SHALL implement FSM IDLE, STREAM, FLUSH, DONE.
REQ-020 SHALL set in_ready=1 in IDLE and STREAM, 0 in FLUSH and DONE.
REQ-021 IDLE: accepted beat with in_last=0 -> STREAM; with in_last=1 -> FLUSH; otherwise stay.
REQ-022 STREAM: accepted beat with in_last=1 -> FLUSH; else stay; cycles without a beat insert a bubble.
REQ-023 FLUSH: SHALL last exactly N cycles (down-counter loaded with N-1 on entry), then -> DONE.
REQ-024 DONE: SHALL assert done=1 for that single cycle, then -> IDLE.
REQ-025 Lane i of a_row/b_col/lane_valid SHALL present the beat accepted at cycle t during cycle t+1+i (all outputs registered).
REQ-026 A cycle with no accepted beat SHALL propagate as lane_valid[i]=0 at t+1+i, data lanes forced to 0.
REQ-027 With last beat accepted at cycle t, lane N-1 SHALL present it at t+N, and done SHALL pulse at t+N+1.
REQ-028 beat_count SHALL clear on the first accepted beat of a tile (loading 1), increment per accepted beat, saturate at K_MAX, and hold after done.
REQ-029 overflow SHALL set when a beat is accepted with beat_count==K_MAX, and clear only on rst or first beat of the next tile.
REQ-030 Operands SHALL pass unmodified (no arithmetic, no sign change).
REQ-031 in_valid while in_ready=0 SHALL be ignored; no data captured; upstream holds.

Reset
REQ-032 On rst: state=IDLE, all delay-line registers=0, a_row=0, b_col=0, lane_valid=0, done=0, beat_count=0, overflow=0; busy=0, in_ready=1 after rst deasserts.
REQ-033 rst mid-tile SHALL discard all in-flight beats immediately; no done pulse for the aborted tile.

Structure
REQ-034 Shared package npu_pkg SHALL hold default DATA_WIDTH, N, K_MAX and the feeder state enum type.
REQ-035 Sub-module skew_delay_line (parameters WIDTH, DEPTH; DEPTH registers of WIDTH+1 bits carrying data+valid) SHALL be instantiated per lane per operand with DEPTH=i+1.

Verification (N=4, DATA_WIDTH=16)
REQ-036 Reset: assert rst mid-FLUSH -> all outputs 0, busy=0 same cycle; no done; next tile runs normally.
REQ-037 Single beat in_a={4,3,2,1}, in_b={8,7,6,5}, in_last=1 at t -> a_row lane0=1 at t+1, lane3=4 at t+4, lane_valid one-hot walking 0001..1000, done at t+5, beat_count=1.
REQ-038 Four back-to-back beats, last at t -> in_ready=0 for t+1..t+5, lane_valid[3]=1 t+1..t+4 after skew, done at t+5, beat_count=4.
REQ-039 Beats at t, t+2 (bubble at t+1) -> lane_valid[2] pattern 1,0,1 starting t+3, data 0 in bubble slot.
REQ-040 in_valid held high during FLUSH with value 0x7FFF -> not accepted, never appears on any lane, beat_count unchanged.
REQ-041 K_MAX=3, send 5 beats -> beat_count saturates 3, overflow=1 after 4th beat, cleared on first beat of next tile.
